// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing for the two-port frame-aware FIFO write arbiter.
`timescale 1ns/1ps
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int unsigned FIFO_DEPTH  = 32;
    localparam int unsigned USEDW_WIDTH = $clog2(FIFO_DEPTH) + 1;

endpackage

// File: rtl/fifo1c_wr_arb2_sat_cnt.sv
// Saturating event counter with synchronous clear; clear wins over increment.
`timescale 1ns/1ps
module sat_cnt #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fifo1c_wr_arb2.sv
// Two-producer write arbiter in front of a single-clock FIFO: frame-locked grant,
// round-robin between frames, space-based backpressure and per-port frame counts.
`timescale 1ns/1ps
module fifo1c_wr_arb2
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DEPTH      = FIFO_DEPTH,
    parameter int unsigned DATA_WIDTH = 144,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0_valid,
    input  logic [DATA_WIDTH-1:0]   req0_data,
    input  logic                    req0_eop,
    output logic                    req0_ready,
    input  logic                    req1_valid,
    input  logic [DATA_WIDTH-1:0]   req1_data,
    input  logic                    req1_eop,
    output logic                    req1_ready,
    output logic [DATA_WIDTH-1:0]   fifo_data,
    output logic                    fifo_wrreq,
    input  logic [$clog2(DEPTH):0]  fifo_usedw,
    output logic [1:0]              grant,
    output logic [CNT_WIDTH-1:0]    frm_cnt0,
    output logic [CNT_WIDTH-1:0]    frm_cnt1,
    input  logic                    cnt_clr
);

    localparam int unsigned UW = (DEPTH == FIFO_DEPTH) ? USEDW_WIDTH : $clog2(DEPTH) + 1;

    arb_state_t              state_q, state_d;
    logic                    last_owner_q, last_owner_d;
    logic                    fifo_wrreq_q, fifo_wrreq_d;
    logic [DATA_WIDTH-1:0]   fifo_data_q, fifo_data_d;

    logic [UW:0]             fill;
    logic                    space_ok;
    logic                    acc0, acc1;
    logic                    eop0_acc, eop1_acc;

    // One extra bit so usedw + pending write can never wrap before the compare.
    assign fill     = {1'b0, fifo_usedw} + {{UW{1'b0}}, fifo_wrreq_q};
    assign space_ok = fill < (UW + 1)'(DEPTH);

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        fifo_wrreq_d = 1'b0;
        fifo_data_d  = fifo_data_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0_valid && !req1_valid) begin
                    state_d = OWN0;
                end else if (req1_valid && !req0_valid) begin
                    state_d = OWN1;
                end else if (req0_valid && req1_valid) begin
                    state_d = last_owner_q ? OWN0 : OWN1;
                end
            end
            OWN0: begin
                req0_ready = space_ok;
                if (req0_valid && space_ok && req0_eop) begin
                    last_owner_d = 1'b0;
                    if (req1_valid) begin
                        state_d = OWN1;
                    end else if (req0_valid) begin
                        state_d = OWN0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            OWN1: begin
                req1_ready = space_ok;
                if (req1_valid && space_ok && req1_eop) begin
                    last_owner_d = 1'b1;
                    if (req0_valid) begin
                        state_d = OWN0;
                    end else if (req1_valid) begin
                        state_d = OWN1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (req0_valid && req0_ready) begin
            fifo_wrreq_d = 1'b1;
            fifo_data_d  = req0_data;
        end else if (req1_valid && req1_ready) begin
            fifo_wrreq_d = 1'b1;
            fifo_data_d  = req1_data;
        end
    end

    assign acc0     = req0_valid && req0_ready;
    assign acc1     = req1_valid && req1_ready;
    assign eop0_acc = acc0 && req0_eop;
    assign eop1_acc = acc1 && req1_eop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            fifo_wrreq_q <= 1'b0;
            fifo_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            fifo_wrreq_q <= fifo_wrreq_d;
            fifo_data_q  <= fifo_data_d;
        end
    end

    assign grant      = {state_q == OWN1, state_q == OWN0};
    assign fifo_wrreq = fifo_wrreq_q;
    assign fifo_data  = fifo_data_q;

    sat_cnt #(.WIDTH(CNT_WIDTH)) u_cnt0 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (eop0_acc),
        .cnt   (frm_cnt0)
    );

    sat_cnt #(.WIDTH(CNT_WIDTH)) u_cnt1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (eop1_acc),
        .cnt   (frm_cnt1)
    );

endmodule

// File: tb/tb_fifo1c_wr_arb2.sv
// Directed bench for fifo1c_wr_arb2 with hand-computed expected values.
`timescale 1ns/1ps
module tb_fifo1c_wr_arb2;
    import fifo_arb_pkg::*;

    localparam int unsigned DW = 144;
    localparam int unsigned CW = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   req0_valid, req1_valid;
    logic [DW-1:0]          req0_data, req1_data;
    logic                   req0_eop, req1_eop;
    logic                   req0_ready, req1_ready;
    logic [DW-1:0]          fifo_data;
    logic                   fifo_wrreq;
    logic [USEDW_WIDTH-1:0] fifo_usedw;
    logic [1:0]             grant;
    logic [CW-1:0]          frm_cnt0, frm_cnt1;
    logic                   cnt_clr;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    fifo1c_wr_arb2 #(.DEPTH(32), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_eop   (req0_eop),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_eop   (req1_eop),
        .req1_ready (req1_ready),
        .fifo_data  (fifo_data),
        .fifo_wrreq (fifo_wrreq),
        .fifo_usedw (fifo_usedw),
        .grant      (grant),
        .frm_cnt0   (frm_cnt0),
        .frm_cnt1   (frm_cnt1),
        .cnt_clr    (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_data = '0; req0_eop = 1'b0;
        req1_valid = 1'b0; req1_data = '0; req1_eop = 1'b0;
        fifo_usedw = '0;
        cnt_clr    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    function automatic logic [DW-1:0] beat(input int unsigned port, input int unsigned idx);
        beat = DW'(((port == 0) ? 32'hA000 : 32'hB000) + idx);
    endfunction

    initial begin
        int unsigned b0, b1, p, idx;
        logic a0, a1;

        // Reset state
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) cyc();
        chk("rst_grant", DW'(grant), DW'(2'b00));
        chk("rst_wrreq", DW'(fifo_wrreq), DW'(0));
        chk("rst_data", fifo_data, '0);
        chk("rst_cnt0", DW'(frm_cnt0), DW'(0));
        chk("rst_cnt1", DW'(frm_cnt1), DW'(0));
        chk("rst_rdy0", DW'(req0_ready), DW'(0));
        chk("rst_rdy1", DW'(req1_ready), DW'(0));
        rst_n = 1'b1;

        // Single port, 3-beat frame
        req0_valid = 1'b1; req0_data = beat(0, 0); req0_eop = 1'b0;
        #1;
        chk("sp_idle_rdy0", DW'(req0_ready), DW'(0));
        cyc();
        chk("sp_grant", DW'(grant), DW'(2'b01));
        chk("sp_rdy0", DW'(req0_ready), DW'(1));
        chk("sp_rdy1", DW'(req1_ready), DW'(0));
        chk("sp_wr_none", DW'(fifo_wrreq), DW'(0));
        cyc();
        chk("sp_wr0", DW'(fifo_wrreq), DW'(1));
        chk("sp_d0", fifo_data, beat(0, 0));
        req0_data = beat(0, 1);
        cyc();
        chk("sp_wr1", DW'(fifo_wrreq), DW'(1));
        chk("sp_d1", fifo_data, beat(0, 1));
        req0_data = beat(0, 2); req0_eop = 1'b1;
        cyc();
        chk("sp_wr2", DW'(fifo_wrreq), DW'(1));
        chk("sp_d2", fifo_data, beat(0, 2));
        chk("sp_cnt0", DW'(frm_cnt0), DW'(1));
        req0_valid = 1'b0; req0_eop = 1'b0;
        cyc();
        chk("sp_wr_end", DW'(fifo_wrreq), DW'(0));
        chk("sp_hold", fifo_data, beat(0, 2));

        // Contention: 2-beat frames from both ports, expect 0,1,0,1 with no bubble
        do_reset();
        b0 = 0; b1 = 0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = beat(0, 0); req0_eop = 1'b0;
        req1_data = beat(1, 0); req1_eop = 1'b0;
        cyc();
        chk("ct_grant_first", DW'(grant), DW'(2'b01));
        for (int k = 0; k < 8; k++) begin
            req0_data = beat(0, b0); req0_eop = b0[0];
            req1_data = beat(1, b1); req1_eop = b1[0];
            #1;
            a0 = req0_ready; a1 = req1_ready;
            cyc();
            if (a0) b0++;
            if (a1) b1++;
            p   = (k >> 1) & 1;
            idx = (k >> 2) * 2 + (k & 1);
            chk($sformatf("ct_wr%0d", k), DW'(fifo_wrreq), DW'(1));
            chk($sformatf("ct_d%0d", k), fifo_data, beat(p, idx));
        end
        chk("ct_cnt0", DW'(frm_cnt0), DW'(2));
        chk("ct_cnt1", DW'(frm_cnt1), DW'(2));

        // Backpressure at the full boundary
        do_reset();
        fifo_usedw = USEDW_WIDTH'(31);
        req1_valid = 1'b1; req1_data = beat(1, 0); req1_eop = 1'b0;
        cyc();
        chk("bp_grant", DW'(grant), DW'(2'b10));
        chk("bp_rdy_31", DW'(req1_ready), DW'(1));
        cyc();
        chk("bp_wr0", DW'(fifo_wrreq), DW'(1));
        chk("bp_d0", fifo_data, beat(1, 0));
        chk("bp_rdy_31_wr", DW'(req1_ready), DW'(0));
        req1_data = beat(1, 1); req1_eop = 1'b1;
        fifo_usedw = USEDW_WIDTH'(32);
        #1;
        chk("bp_rdy_32", DW'(req1_ready), DW'(0));
        cyc();
        chk("bp_wr_stall", DW'(fifo_wrreq), DW'(0));
        chk("bp_d_hold", fifo_data, beat(1, 0));
        chk("bp_rdy_32_b", DW'(req1_ready), DW'(0));
        fifo_usedw = USEDW_WIDTH'(30);
        #1;
        chk("bp_rdy_30", DW'(req1_ready), DW'(1));
        cyc();
        chk("bp_wr1", DW'(fifo_wrreq), DW'(1));
        chk("bp_d1", fifo_data, beat(1, 1));
        chk("bp_cnt1", DW'(frm_cnt1), DW'(1));

        // Saturation and clear priority
        do_reset();
        req0_valid = 1'b1; req0_eop = 1'b1; req0_data = beat(0, 7);
        cyc();
        repeat (65534) cyc();
        chk("sat_fffe", DW'(frm_cnt0), DW'(16'hFFFE));
        cyc();
        chk("sat_ffff", DW'(frm_cnt0), DW'(16'hFFFF));
        repeat (3) cyc();
        chk("sat_hold", DW'(frm_cnt0), DW'(16'hFFFF));
        cnt_clr = 1'b1;
        cyc();
        chk("clr_pri", DW'(frm_cnt0), DW'(0));
        cnt_clr = 1'b0;
        cyc();
        chk("clr_then_inc", DW'(frm_cnt0), DW'(1));

        // Mid-frame reset during beat 2 of a 4-beat frame
        do_reset();
        req0_valid = 1'b1; req0_eop = 1'b0; req0_data = beat(0, 0);
        cyc();
        cyc();
        req0_data = beat(0, 1);
        rst_n = 1'b0;
        cyc();
        chk("mr_grant", DW'(grant), DW'(2'b00));
        chk("mr_wrreq", DW'(fifo_wrreq), DW'(0));
        chk("mr_data", fifo_data, '0);
        chk("mr_cnt0", DW'(frm_cnt0), DW'(0));
        rst_n = 1'b1;
        req0_data = beat(0, 9); req0_eop = 1'b1;
        cyc();
        chk("mr_regrant", DW'(grant), DW'(2'b01));
        cyc();
        chk("mr_wr", DW'(fifo_wrreq), DW'(1));
        chk("mr_d", fifo_data, beat(0, 9));
        chk("mr_cnt0_new", DW'(frm_cnt0), DW'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
